// File: rtl/video_timing_pkg.sv
// Shared constants for the video timing block: 720p60 defaults, dd1 bus
// field offsets and the pixel-aligner state encoding.
package video_timing_pkg;

    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 110;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BP     = 220;
    localparam int DEF_V_ACTIVE = 720;
    localparam int DEF_V_FP     = 5;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 20;
    localparam bit DEF_HS_POL   = 1'b1;
    localparam bit DEF_VS_POL   = 1'b1;

    // dd1 = {R[7:0], G[7:0], B[7:0], DE, HSYNC, VSYNC}
    localparam int DD1_W  = 27;
    localparam int DD1_VS = 0;
    localparam int DD1_HS = 1;
    localparam int DD1_DE = 2;
    localparam int DD1_B  = 3;
    localparam int DD1_G  = 11;
    localparam int DD1_R  = 19;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } sync_state_t;

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: wrapping counter with active-region and sync-pulse decode.
module timing_axis_counter #(
    parameter int ACTIVE = 8,
    parameter int FP     = 2,
    parameter int SYNC   = 2,
    parameter int BP     = 4,
    parameter bit POL    = 1'b1,
    parameter int W      = $clog2(ACTIVE + FP + SYNC + BP)
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         active,
    output logic         sync
);
    localparam int TOTAL    = ACTIVE + FP + SYNC + BP;
    localparam int SYNC_BEG = ACTIVE + FP;
    localparam int SYNC_END = SYNC_BEG + SYNC;

    int c;
    assign c      = int'(cnt);
    assign wrap   = inc && (c == TOTAL - 1);
    assign active = c < ACTIVE;
    assign sync   = (c >= SYNC_BEG && c < SYNC_END) ? POL : ~POL;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)  cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= wrap ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/video_timing.sv
// Video timing generator: raster counters, sync decode and a pixel-stream
// aligner that locks the upstream frame (pix_sof) to raster position (0,0).
module video_timing
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = DEF_HS_POL,
    parameter bit VS_POL   = DEF_VS_POL
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             pix_valid,
    input  logic [23:0]      pix_rgb,
    input  logic             pix_sof,
    output logic             pix_ready,
    output logic [DD1_W-1:0] dd1,
    output logic             frame_start,
    output logic             underflow,
    output logic             sync_err
);
    localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [DD1_W-1:0] DD1_RST = {24'h0, 1'b0, ~HS_POL, ~VS_POL};

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap, v_wrap, h_act, v_act, hs, vs;

    timing_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .W(HW)
    ) u_h (
        .clk(clk), .resetn(resetn), .clr(~en), .inc(en),
        .cnt(h_cnt), .wrap(h_wrap), .active(h_act), .sync(hs)
    );

    timing_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .W(VW)
    ) u_v (
        .clk(clk), .resetn(resetn), .clr(~en), .inc(h_wrap),
        .cnt(v_cnt), .wrap(v_wrap), .active(v_act), .sync(vs)
    );

    sync_state_t state, nxt_state;
    logic        blank, nxt_blank;  // misplaced sof seen: dark until frame end
    logic        de, first, take, show, set_uf, set_se;
    logic [DD1_W-1:0] dd1_d;

    assign de    = en && h_act && v_act;
    assign first = de && (h_cnt == '0) && (v_cnt == '0);

    always_comb begin
        take      = 1'b0;
        show      = 1'b0;
        set_uf    = 1'b0;
        set_se    = 1'b0;
        nxt_state = state;
        nxt_blank = v_wrap ? 1'b0 : blank;
        case (state)
            SEARCH: begin
                // Locking pixel is frame position (0,0), so it is displayed.
                if (first) begin
                    if (pix_valid && pix_sof) begin
                        take      = 1'b1;
                        show      = 1'b1;
                        nxt_state = LOCKED;
                    end
                end else begin
                    take = pix_valid && !pix_sof;
                end
            end
            LOCKED: begin
                if (first) begin
                    nxt_blank = 1'b0;
                    if (!pix_valid) set_uf = 1'b1;
                    else if (pix_sof) begin
                        take = 1'b1;
                        show = 1'b1;
                    end else begin
                        set_se    = 1'b1;
                        nxt_state = SEARCH;
                    end
                end else if (de && !blank) begin
                    if (!pix_valid) set_uf = 1'b1;
                    else if (pix_sof) begin
                        set_se    = 1'b1;
                        nxt_blank = 1'b1;
                    end else begin
                        take = 1'b1;
                        show = 1'b1;
                    end
                end
            end
            default: nxt_state = SEARCH;
        endcase
        if (!en) begin
            take      = 1'b0;
            show      = 1'b0;
            nxt_state = SEARCH;
            nxt_blank = 1'b0;
        end
    end

    assign pix_ready = resetn && take;

    always_comb begin
        dd1_d                = '0;
        dd1_d[DD1_R +: 8]    = show ? pix_rgb[23:16] : 8'h0;
        dd1_d[DD1_G +: 8]    = show ? pix_rgb[15:8]  : 8'h0;
        dd1_d[DD1_B +: 8]    = show ? pix_rgb[7:0]   : 8'h0;
        dd1_d[DD1_DE]        = de;
        dd1_d[DD1_HS]        = en ? hs : ~HS_POL;
        dd1_d[DD1_VS]        = en ? vs : ~VS_POL;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= SEARCH;
            blank       <= 1'b0;
            dd1         <= DD1_RST;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= nxt_state;
            blank       <= nxt_blank;
            dd1         <= dd1_d;
            frame_start <= first;
            underflow   <= underflow | set_uf;
            sync_err    <= sync_err | set_se;
        end
    end

endmodule
